fb_address_generator: RTL and testbench

Pipelined, parametrised framebuffer address generator that converts VGA beam / writer coordinates (curX, curY) into a linear SRAM word address, with multi-buffer (double/triple) framebuffer support. It sits between the VGA controller or fractal pixel writer and the frame-buffer SRAM interface. It adds a registered two-stage pipeline, out-of-bounds detection, and frame-synchronous front/back buffer swapping on top of the plain y*H_RES+x mapping.

---
 rtl/fb_address_generator_pkg.sv | 29 ++
 rtl/fb_address_generator_if.sv | 28 ++
 rtl/fb_address_generator_const_row_mult.sv | 18 +
 rtl/fb_address_generator.sv | 110 +++++++++++
 tb/tb_fb_address_generator.sv | 126 ++++++++++++
 5 files changed

// File: rtl/fb_address_generator_pkg.sv
// fb_pkg: shared framebuffer geometry defaults, sizing helpers and swap FSM states
package fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam longint FB_WORDS = longint'(H_RES_DEF) * longint'(V_RES_DEF);

    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    function automatic int clog2(input longint value);
        int bits;
        longint v;
        bits = 0;
        v = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v = v >> 1;
        end
        return bits;
    endfunction

    function automatic longint fb_words(input int h_res, input int v_res);
        return longint'(h_res) * longint'(v_res);
    endfunction

endpackage

// File: rtl/fb_address_generator_if.sv
// fb_address_generator_if: coordinate/swap inputs and address/buffer-state outputs
interface fb_address_generator_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 20
);
    logic              frame_start;
    logic              swap_req;
    logic              coord_valid;
    logic [X_W-1:0]    curX;
    logic [Y_W-1:0]    curY;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              oob;
    logic [1:0]        front_buf;
    logic [1:0]        back_buf;
    logic              swap_pending;

    modport master (
        output frame_start, swap_req, coord_valid, curX, curY,
        input  address, addr_valid, oob, front_buf, back_buf, swap_pending
    );

    modport slave (
        input  frame_start, swap_req, coord_valid, curX, curY,
        output address, addr_valid, oob, front_buf, back_buf, swap_pending
    );
endinterface

// File: rtl/fb_address_generator_const_row_mult.sv
// const_row_mult: y * H_RES as a shift-add over the set bits of the constant H_RES
module const_row_mult #(
    parameter int Y_W   = 9,
    parameter int H_RES = 640,
    parameter int OUT_W = 20
) (
    input  logic [Y_W-1:0]   y,
    output logic [OUT_W-1:0] p
);
    localparam logic [31:0] K = 32'(H_RES);

    // one shifted copy of y per set bit of H_RES; unset bits fold away at elaboration
    always_comb begin
        p = '0;
        for (int i = 0; i < 32; i++)
            p = p + (K[i] ? (OUT_W'(y) << i) : '0);
    end
endmodule

// File: rtl/fb_address_generator.sv
// fb_address_generator: two-stage (x,y) -> linear SRAM address with multi-buffer swap control
module fb_address_generator
    import fb_pkg::*;
#(
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int NUM_BUFFERS = 2,
    parameter int ADDR_W      = 20
) (
    input  logic Clk,
    input  logic Reset_n,
    fb_address_generator_if.slave bus
);
    localparam longint WORDS = fb_words(H_RES, V_RES);
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(WORDS);
    localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * WORDS);
    localparam logic [ADDR_W-1:0] BASE3 = ADDR_W'(3 * WORDS);
    localparam logic [1:0] LAST = 2'(NUM_BUFFERS - 1);
    localparam logic MULTI = NUM_BUFFERS > 1;

    logic [ADDR_W-1:0] row_prod;
    logic [ADDR_W-1:0] base_sel;
    logic              in_range;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] base_q;
    logic [X_W-1:0]    x_q;
    logic              v1;
    logic              r1;
    logic [ADDR_W-1:0] address_q;
    logic              addr_valid_q;
    logic              oob_q;
    swap_state_t       state;
    logic [1:0]        front_q;
    logic [1:0]        back_q;
    logic              apply;
    logic [1:0]        nxt1;
    logic [1:0]        nxt2;

    const_row_mult #(
        .Y_W  (Y_W),
        .H_RES(H_RES),
        .OUT_W(ADDR_W)
    ) u_row (
        .y(bus.curY),
        .p(row_prod)
    );

    // range compare, base table lookup and swap decisions from current state
    always_comb begin
        in_range = (32'(bus.curX) < 32'(H_RES)) && (32'(bus.curY) < 32'(V_RES));
        base_sel = front_q == 2'd0 ? '0 : front_q == 2'd1 ? BASE1 : front_q == 2'd2 ? BASE2 : BASE3;
        apply    = MULTI && bus.frame_start && (bus.swap_req || state == SWAP_PENDING);
        nxt1     = front_q == LAST ? 2'd0 : front_q + 2'd1;
        nxt2     = nxt1 == LAST ? 2'd0 : nxt1 + 2'd1;
    end

    // stage 1: capture row offset, column and base (pre-swap front buffer)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_q  <= '0;
            base_q <= '0;
            x_q    <= '0;
            v1     <= 1'b0;
            r1     <= 1'b0;
        end else begin
            row_q  <= row_prod;
            base_q <= base_sel;
            x_q    <= bus.curX;
            v1     <= bus.coord_valid;
            r1     <= in_range;
        end
    end

    // stage 2: sum the address for in-range coordinates, otherwise hold it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            address_q    <= '0;
            addr_valid_q <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            address_q    <= (v1 && r1) ? base_q + row_q + ADDR_W'(x_q) : address_q;
            addr_valid_q <= v1 && r1;
            oob_q        <= v1 && !r1;
        end
    end

    // swap FSM: a request waits for frame_start unless both arrive together
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= SWAP_IDLE;
            front_q <= 2'd0;
            back_q  <= 2'(MULTI);
        end else if (apply) begin
            state   <= SWAP_IDLE;
            front_q <= nxt1;
            back_q  <= nxt2;
        end else if (MULTI && bus.swap_req) begin
            state   <= SWAP_PENDING;
        end
    end

    assign bus.address      = address_q;
    assign bus.addr_valid   = addr_valid_q;
    assign bus.oob          = oob_q;
    assign bus.front_buf    = front_q;
    assign bus.back_buf     = back_q;
    assign bus.swap_pending = state == SWAP_PENDING;
endmodule

// File: tb/tb_fb_address_generator.sv
// tb_fb_address_generator: scoreboard bench for address mapping, bounds, swap and reset
module tb_fb_address_generator;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    fb_address_generator_if #(.X_W(10), .Y_W(9), .ADDR_W(20)) bus ();

    fb_address_generator #(
        .H_RES(640), .V_RES(480), .X_W(10), .Y_W(9), .NUM_BUFFERS(2), .ADDR_W(20)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        v;
        logic        o;
        logic [19:0] a;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          m_front = 0;
    logic        m_pend = 1'b0;
    logic [19:0] m_last = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit fs, input bit sr, input bit cv, input int x, input int y);
        exp_t e;
        exp_t o;
        bit   inr;
        Reset_n         = !rst;
        bus.frame_start = fs;
        bus.swap_req    = sr;
        bus.coord_valid = cv;
        bus.curX        = 10'(x);
        bus.curY        = 9'(y);
        inr = (x < 640) && (y < 480);
        if (rst) begin
            q.delete();
            q.push_back('0);
            m_front = 0;
            m_pend  = 1'b0;
            m_last  = '0;
        end else begin
            e.v = cv && inr;
            e.o = cv && !inr;
            if (e.v) m_last = 20'(m_front * 307200 + y * 640 + x);
            e.a = m_last;
            q.push_back(e);
            if (fs && (sr || m_pend)) begin
                m_front = (m_front + 1) % 2;
                m_pend  = 1'b0;
            end else if (sr) begin
                m_pend = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        if (rst) begin
            chk("rst_address", 32'(bus.address), 0);
            chk("rst_addr_valid", 32'(bus.addr_valid), 0);
            chk("rst_oob", 32'(bus.oob), 0);
        end else if (q.size() == 2) begin
            o = q.pop_front();
            chk("addr_valid", 32'(bus.addr_valid), 32'(o.v));
            chk("oob", 32'(bus.oob), 32'(o.o));
            chk("address", 32'(bus.address), 32'(o.a));
        end
        chk("front_buf", 32'(bus.front_buf), 32'(m_front));
        chk("back_buf", 32'(bus.back_buf), 32'((m_front + 1) % 2));
        chk("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 511));
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 639, 0);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 639, 479);
        idle(2);
        cyc(0, 0, 0, 1, 640, 0);
        cyc(0, 0, 0, 1, 0, 480);
        cyc(0, 0, 0, 1, 1023, 511);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0);
        idle(4);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 2);
        cyc(0, 0, 0, 1, 3, 0);
        idle(2);
        cyc(0, 0, 0, 1, 5, 5);
        cyc(1, 0, 0, 1, 9, 9);
        cyc(0, 0, 0, 1, 7, 0);
        idle(2);
        for (int i = 0; i < 80; i++)
            cyc(0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 700), $urandom_range(0, 511));
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
